pc_fetch_unit: RTL and testbench

Program-counter and fetch-sequencing stage directly upstream of the instruction memory. It holds the architectural PC, computes the next PC (sequential, branch/JAL, JALR), applies stalls, traps misaligned or out-of-range fetch targets, and keeps the cycle and retired-instruction counters. Its `PC` output drives the instruction memory address; redirect inputs come from the decode/execute logic of the single-cycle core.

---
 rtl/pc_fetch_unit_pkg.sv | 24 ++
 rtl/pc_fetch_unit_if.sv | 32 +++
 rtl/pc_fetch_unit_next_pc_calc.sv | 34 +++
 rtl/pc_fetch_unit.sv | 94 +++++++++
 tb/tb_pc_fetch_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared widths, defaults and state encoding for the fetch stage
package pc_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int              DEFAULT_IMEM_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // JALR targets always have bit 0 forced low before the legality check.
  function automatic logic [XLEN-1:0] jalr_target(input logic [XLEN-1:0] base,
                                                  input logic [XLEN-1:0] offset);
    logic [XLEN-1:0] sum;
    sum = base + offset;
    return sum & ~32'h1;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - redirect inputs and fetch/status outputs of the fetch stage
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic            Stall;
  logic            Branch_Taken;
  logic            Jump;
  logic            Jalr;
  logic [XLEN-1:0] Imm;
  logic [XLEN-1:0] RS1_Data;

  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PC_Plus4;
  logic            Fetch_Valid;
  logic            Fault;
  logic [XLEN-1:0] Fault_PC;
  logic [63:0]     Cycle_Count;
  logic [63:0]     Instret_Count;

  // Decode/execute side: drives redirects, observes the fetch address and status.
  modport master (
    output Stall, Branch_Taken, Jump, Jalr, Imm, RS1_Data,
    input  PC, PC_Plus4, Fetch_Valid, Fault, Fault_PC, Cycle_Count, Instret_Count
  );

  // Fetch unit side.
  modport slave (
    input  Stall, Branch_Taken, Jump, Jalr, Imm, RS1_Data,
    output PC, PC_Plus4, Fetch_Valid, Fault, Fault_PC, Cycle_Count, Instret_Count
  );

endinterface

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// rtl/pc_fetch_unit_next_pc_calc.sv - candidate next-PC selection and fetch legality check
module next_pc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic            jalr_i,
  input  logic            jump_i,
  input  logic            branch_taken_i,
  output logic [XLEN-1:0] cand_o,
  output logic            legal_o
);

  localparam logic [XLEN-1:0] IMEM_WORDS_W = XLEN'(IMEM_WORDS);

  // Priority: JALR beats JAL/branch, which beat the sequential path. Sums wrap mod 2^32.
  always_comb begin
    cand_o = pc_i + 32'd4;
    if (jalr_i) begin
      cand_o = jalr_target(rs1_data_i, imm_i);
    end else if (jump_i || branch_taken_i) begin
      cand_o = pc_i + imm_i;
    end
  end

  // Word-aligned and inside [0, 4*IMEM_WORDS); checked on the wrapped sum.
  always_comb begin
    legal_o = (cand_o[1:0] == 2'b00) && ({2'b00, cand_o[XLEN-1:2]} < IMEM_WORDS_W);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, boot/run/fault sequencing, fault capture and counters
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic            clk,
  input  logic            Rst,
  pc_fetch_unit_if.slave  fif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic [63:0]     cycle_q, cycle_d;
  logic [63:0]     instret_q, instret_d;

  logic [XLEN-1:0] cand;
  logic            cand_legal;

  next_pc_calc #(
    .IMEM_WORDS (IMEM_WORDS)
  ) u_next_pc_calc (
    .pc_i           (pc_q),
    .imm_i          (fif.Imm),
    .rs1_data_i     (fif.RS1_Data),
    .jalr_i         (fif.Jalr),
    .jump_i         (fif.Jump),
    .branch_taken_i (fif.Branch_Taken),
    .cand_o         (cand),
    .legal_o        (cand_legal)
  );

  // Next-state logic: BOOT waits one cycle, RUN advances or traps, FAULT holds until reset.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    instret_d  = instret_q;
    cycle_d    = cycle_q + 64'd1;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!fif.Stall) begin
          if (cand_legal) begin
            pc_d      = cand;
            instret_d = instret_q + 64'd1;
          end else begin
            state_d    = ST_FAULT;
            fault_pc_d = cand;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State, PC, fault capture and counters; reset takes effect without a clock edge.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
      cycle_q    <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
    end
  end

  // Outputs depend only on registered state, never directly on the redirect inputs.
  always_comb begin
    fif.PC            = pc_q;
    fif.PC_Plus4      = pc_q + 32'd4;
    fif.Fetch_Valid   = (state_q == ST_RUN);
    fif.Fault         = (state_q == ST_FAULT);
    fif.Fault_PC      = fault_pc_q;
    fif.Cycle_Count   = cycle_q;
    fif.Instret_Count = instret_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic clk;
  logic Rst;
  int   n_checks;
  int   n_errors;
  logic [63:0] cyc_snap;

  pc_fetch_unit_if fif ();

  pc_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (1024)
  ) dut (
    .clk (clk),
    .Rst (Rst),
    .fif (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    fif.Stall        = 1'b0;
    fif.Branch_Taken = 1'b0;
    fif.Jump         = 1'b0;
    fif.Jalr         = 1'b0;
    fif.Imm          = 32'h0;
    fif.RS1_Data     = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in BOOT, 1 time unit after a rising edge.
  task automatic do_reset();
    idle_inputs();
    Rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    Rst = 1'b0;
  endtask

  task automatic jalr_to(input logic [31:0] addr);
    fif.Jalr     = 1'b1;
    fif.RS1_Data = addr;
    fif.Imm      = 32'h0;
    tick();
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Rst = 1'b1;
    idle_inputs();

    // Reset then free-run
    do_reset();
    check("boot_pc", fif.PC, 64'h0);
    check("boot_valid", fif.Fetch_Valid, 64'h0);
    check("boot_fault", fif.Fault, 64'h0);
    check("boot_fault_pc", fif.Fault_PC, 64'h0);
    check("boot_cycle", fif.Cycle_Count, 64'd0);
    check("boot_instret", fif.Instret_Count, 64'd0);
    tick();
    check("run0_pc", fif.PC, 64'h0);
    check("run0_valid", fif.Fetch_Valid, 64'h1);
    check("run0_cycle", fif.Cycle_Count, 64'd1);
    tick();
    check("seq_pc4", fif.PC, 64'h4);
    tick();
    check("seq_pc8", fif.PC, 64'h8);
    tick();
    check("seq_pc12", fif.PC, 64'hC);
    check("seq_instret3", fif.Instret_Count, 64'd3);
    tick();
    check("seq_cycle5", fif.Cycle_Count, 64'd5);
    check("seq_pc16", fif.PC, 64'h10);
    check("seq_plus4", fif.PC_Plus4, 64'h14);

    // Backward branch then JALR with bit 0 cleared
    fif.Branch_Taken = 1'b1;
    fif.Imm          = 32'hFFFF_FFF8;
    tick();
    idle_inputs();
    check("branch_back", fif.PC, 64'h8);
    fif.Jalr     = 1'b1;
    fif.RS1_Data = 32'h101;
    fif.Imm      = 32'h3;
    tick();
    idle_inputs();
    check("jalr_clear_b0", fif.PC, 64'h104);
    check("jalr_instret", fif.Instret_Count, 64'd6);

    // JALR has priority over JAL
    do_reset();
    tick();
    fif.Jalr     = 1'b1;
    fif.Jump     = 1'b1;
    fif.RS1_Data = 32'h40;
    fif.Imm      = 32'h20;
    tick();
    idle_inputs();
    check("prio_jalr", fif.PC, 64'h60);

    // Stall beats a held JAL; JAL lands once stall drops
    jalr_to(32'h20);
    check("stall_start_pc", fif.PC, 64'h20);
    check("stall_start_instret", fif.Instret_Count, 64'd2);
    fif.Stall = 1'b1;
    fif.Jump  = 1'b1;
    fif.Imm   = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_pc_%0d", i), fif.PC, 64'h20);
    end
    check("stall_instret", fif.Instret_Count, 64'd2);
    fif.Stall = 1'b0;
    tick();
    idle_inputs();
    check("stall_release_pc", fif.PC, 64'h120);
    check("stall_release_instret", fif.Instret_Count, 64'd3);

    // Misaligned JALR target traps; FAULT ignores redirects
    jalr_to(32'h102);
    check("misal_fault", fif.Fault, 64'h1);
    check("misal_fault_pc", fif.Fault_PC, 64'h102);
    check("misal_valid", fif.Fetch_Valid, 64'h0);
    check("misal_pc", fif.PC, 64'h120);
    check("misal_instret", fif.Instret_Count, 64'd3);
    cyc_snap = fif.Cycle_Count;
    fif.Jump = 1'b1;
    fif.Imm  = 32'h4;
    tick();
    tick();
    idle_inputs();
    check("misal_cycle_runs", fif.Cycle_Count, cyc_snap + 64'd2);
    check("misal_pc_frozen", fif.PC, 64'h120);
    check("misal_fault_pc_frozen", fif.Fault_PC, 64'h102);
    check("misal_instret_frozen", fif.Instret_Count, 64'd3);

    // Sequential fetch runs off the end of memory
    do_reset();
    tick();
    jalr_to(32'hFFC);
    check("end_pc", fif.PC, 64'hFFC);
    check("end_valid", fif.Fetch_Valid, 64'h1);
    tick();
    check("end_fault", fif.Fault, 64'h1);
    check("end_fault_pc", fif.Fault_PC, 64'h1000);
    check("end_pc_frozen", fif.PC, 64'hFFC);
    cyc_snap = fif.Cycle_Count;
    tick();
    check("end_cycle_runs", fif.Cycle_Count, cyc_snap + 64'd1);

    // Asynchronous reset while in FAULT at PC=0x40
    do_reset();
    tick();
    jalr_to(32'h40);
    check("async_pre_pc", fif.PC, 64'h40);
    jalr_to(32'h102);
    check("async_pre_fault", fif.Fault, 64'h1);
    check("async_pre_pc_frozen", fif.PC, 64'h40);
    #2;
    Rst = 1'b1;
    #1;
    check("async_pc", fif.PC, 64'h0);
    check("async_fault", fif.Fault, 64'h0);
    check("async_fault_pc", fif.Fault_PC, 64'h0);
    check("async_cycle", fif.Cycle_Count, 64'd0);
    check("async_instret", fif.Instret_Count, 64'd0);
    #1;
    Rst = 1'b0;
    check("async_boot_valid", fif.Fetch_Valid, 64'h0);
    tick();
    check("async_run_valid", fif.Fetch_Valid, 64'h1);
    check("async_run_pc", fif.PC, 64'h0);
    tick();
    check("async_run_pc4", fif.PC, 64'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
